// File: rtl/silife_pkg.sv
// silife_pkg: shared types, widths and cell indexing for the silife blocks
package silife_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_STEP} stepper_state_t;
  localparam int GEN_BITS = 32;
  function automatic int cell_index(int row, int col, int width);
    return row * width + col;
  endfunction
endpackage

// File: rtl/silife_step_timer.sv
// silife_step_timer: free-running period counter with terminal-count expiry
module silife_step_timer #(
  parameter int PERIOD_BITS = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   restart,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   expire
);
  logic [PERIOD_BITS-1:0] count;
  // >= rather than == so a shrinking period expires on the next cycle
  assign expire = run && count >= ((period == '0) ? '0 : period - 1'b1);
  always_ff @(posedge clk)
    count <= (reset || !run || restart || expire) ? '0 : count + 1'b1;
endmodule

// File: rtl/silife_stepper.sv
// silife_stepper: generation scheduler and edit/step arbiter for silife_matrix
// Optional generation limit and halt: define SILIFE_STEPPER_MAX_GEN_EN
module silife_stepper
  import silife_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 8,
  parameter int PERIOD_BITS = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       step_req,
  input  logic [PERIOD_BITS-1:0]     period,
  input  logic                       edit_valid,
  output logic                       edit_ready,
  input  logic                       edit_set,
  input  logic [$clog2(HEIGHT)-1:0]  edit_row,
  input  logic [$clog2(WIDTH)-1:0]   edit_col,
  output logic                       step_en,
  output logic [HEIGHT*WIDTH-1:0]    set_cells,
  output logic [HEIGHT*WIDTH-1:0]    clear_cells,
  output logic [GEN_BITS-1:0]        generation,
  output logic                       busy
`ifdef SILIFE_STEPPER_MAX_GEN_EN
  ,
  input  logic [GEN_BITS-1:0]        max_gen,
  output logic                       halted
`endif
);
  localparam int N = HEIGHT * WIDTH;
  stepper_state_t state, state_nx;
  logic step_pending, e_set, expire, req_ok, tick, stop, go, in_range;
  logic [$clog2(HEIGHT)-1:0] e_row;
  logic [$clog2(WIDTH)-1:0] e_col;
  logic [N-1:0] cell_bit;
`ifdef SILIFE_STEPPER_MAX_GEN_EN
  logic run_q;
  // stop also covers the cycle before halted rises so no extra step slips in
  assign stop = halted || (max_gen != '0 && generation == max_gen);
  always_ff @(posedge clk) begin
    run_q <= reset ? 1'b0 : run;
    if (reset) halted <= 1'b0;
    else if (run && !run_q && generation != max_gen) halted <= 1'b0;
    else if (max_gen != '0 && generation == max_gen) halted <= 1'b1;
  end
`else
  assign stop = 1'b0;
`endif
  assign req_ok = step_req && !stop;
  assign tick   = (expire || req_ok) && !stop;
  assign go     = step_pending && !stop;
  silife_step_timer #(.PERIOD_BITS(PERIOD_BITS)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .restart (req_ok),
    .period  (period),
    .expire  (expire)
  );
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : state_nx;
  always_comb
    state_nx = (state == S_STEP) ? S_IDLE :
               (state == S_IDLE) ? (edit_valid ? S_EDIT : go ? S_STEP : S_IDLE) :
               (go ? S_STEP : edit_valid ? S_EDIT : S_IDLE);
  always_ff @(posedge clk) begin
    if (reset) begin
      step_pending <= 1'b0;
      generation   <= '0;
      e_set        <= 1'b0;
      e_row        <= '0;
      e_col        <= '0;
    end else begin
      step_pending <= tick || (step_pending && state != S_STEP && !stop);
      if (state == S_STEP) generation <= generation + 1'b1;
      if (edit_valid && edit_ready) begin
        e_set <= edit_set;
        e_row <= edit_row;
        e_col <= edit_col;
      end
    end
  end
  always_comb begin
    edit_ready  = state == S_IDLE || (state == S_EDIT && !go);
    step_en     = state == S_STEP;
    busy        = state != S_IDLE || step_pending;
    in_range    = int'(e_row) < HEIGHT && int'(e_col) < WIDTH;
    cell_bit    = in_range ? {{(N-1){1'b0}}, 1'b1} << cell_index(int'(e_row), int'(e_col), WIDTH) : '0;
    set_cells   = (state == S_EDIT && e_set) ? cell_bit : '0;
    clear_cells = (state == S_EDIT && !e_set) ? cell_bit : '0;
  end
endmodule

// File: tb/tb_silife_stepper.sv
// tb_silife_stepper: directed vector table plus multi-cycle sequences for silife_stepper
module tb_silife_stepper;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, step_req = 1'b0;
  logic edit_valid = 1'b0, edit_set = 1'b0;
  logic [23:0] period = 24'd4;
  logic [2:0] edit_row = 3'd0, edit_col = 3'd0;
  logic edit_ready, step_en, busy;
  logic [63:0] set_cells, clear_cells;
  logic [31:0] generation;
`ifdef SILIFE_STEPPER_MAX_GEN_EN
  logic [31:0] max_gen = 32'd0;
  logic halted;
`endif
  int passed = 0, total = 0;
  typedef struct {
    logic rn, sr, ev, es;
    logic [2:0] r, c;
    logic se;
    logic [63:0] sc, cc;
    logic [31:0] g;
    logic rdy, bsy;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  silife_stepper dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step_req    (step_req),
    .period      (period),
    .edit_valid  (edit_valid),
    .edit_ready  (edit_ready),
    .edit_set    (edit_set),
    .edit_row    (edit_row),
    .edit_col    (edit_col),
    .step_en     (step_en),
    .set_cells   (set_cells),
    .clear_cells (clear_cells),
    .generation  (generation),
    .busy        (busy)
`ifdef SILIFE_STEPPER_MAX_GEN_EN
    ,
    .max_gen     (max_gen),
    .halted      (halted)
`endif
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step_req = 1'b0; edit_valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask
  function automatic logic [63:0] bitm(input int b);
    logic [63:0] one = 64'd1;
    return (b < 0) ? 64'd0 : one << b;
  endfunction
  task automatic add(input int rn, sr, ev, es, r, c, se, sb, cb, g, rdy, bsy);
    vec_t t;
    t.rn = rn[0]; t.sr = sr[0]; t.ev = ev[0]; t.es = es[0];
    t.r = r[2:0]; t.c = c[2:0]; t.se = se[0];
    t.sc = bitm(sb); t.cc = bitm(cb); t.g = g;
    t.rdy = rdy[0]; t.bsy = bsy[0];
    v.push_back(t);
  endtask
  initial begin
    int n, first, ov, ne;
    int p[3];
    //   rn sr ev es r  c  se  sb  cb  g rdy bsy
    add(0, 1, 0, 0, 0, 0, 0, -1, -1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, -1, -1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, -1, -1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, -1, -1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, -1, -1, 1, 1, 0);
    add(0, 0, 1, 1, 2, 5, 0, -1, -1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 21, -1, 1, 1, 1);
    add(0, 0, 1, 0, 2, 5, 0, -1, -1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, -1, 21, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, -1, -1, 1, 1, 0);
    add(0, 1, 1, 1, 7, 7, 0, -1, -1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 63, -1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, -1, -1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, -1, -1, 2, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, -1, -1, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, -1, -1, 3, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, -1, -1, 3, 1, 0);
    cyc();
    chk("rst_step_en", 64'(step_en), 64'd0);
    chk("rst_set", set_cells, 64'd0);
    chk("rst_clear", clear_cells, 64'd0);
    chk("rst_gen", 64'(generation), 64'd0);
    chk("rst_ready", 64'(edit_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    do_reset();
    foreach (v[i]) begin
      run = v[i].rn; step_req = v[i].sr; edit_valid = v[i].ev;
      edit_set = v[i].es; edit_row = v[i].r; edit_col = v[i].c;
      #1;
      chk($sformatf("v%0d_step_en", i), 64'(step_en), 64'(v[i].se));
      chk($sformatf("v%0d_set", i), set_cells, v[i].sc);
      chk($sformatf("v%0d_clear", i), clear_cells, v[i].cc);
      chk($sformatf("v%0d_gen", i), 64'(generation), 64'(v[i].g));
      chk($sformatf("v%0d_ready", i), 64'(edit_ready), 64'(v[i].rdy));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(v[i].bsy));
      cyc();
    end
    do_reset();
    run = 1'b1; period = 24'd4; n = 0;
    for (int c = 0; c < 14; c++) begin
      if (step_en) begin
        if (n < 3) p[n] = c;
        n++;
      end
      cyc();
    end
    chk("p4_count", 64'(n), 64'd3);
    chk("p4_first", 64'(p[0]), 64'd5);
    chk("p4_second", 64'(p[1]), 64'd9);
    chk("p4_third", 64'(p[2]), 64'd13);
    chk("p4_gen", 64'(generation), 64'd3);
    run = 1'b0; n = 0;
    for (int c = 0; c < 10; c++) begin
      if (step_en) n++;
      cyc();
    end
    chk("stop_pulses", 64'(n), 64'd0);
    chk("stop_gen", 64'(generation), 64'd3);
    do_reset();
    run = 1'b1; period = 24'd0; n = 0; first = -1;
    for (int c = 0; c < 10; c++) begin
      if (step_en) begin
        if (first < 0) first = c;
        n++;
      end
      cyc();
    end
    chk("p0_count", 64'(n), 64'd4);
    chk("p0_first", 64'(first), 64'd2);
    do_reset();
    run = 1'b1; period = 24'd8; first = -1;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) period = 24'd3;
      if (step_en && first < 0) first = c;
      cyc();
    end
    chk("pchg_first", 64'(first), 64'd7);
    do_reset();
    run = 1'b1; period = 24'd1; edit_valid = 1'b1; n = 0; ov = 0; ne = 0;
    for (int c = 0; c < 18; c++) begin
      edit_set = c[0]; edit_row = 3'(c); edit_col = 3'(c + 3);
      #1;
      if (step_en && (set_cells | clear_cells) != 64'd0) ov++;
      if (step_en) n++;
      if ((set_cells | clear_cells) != 64'd0) ne++;
      cyc();
    end
    chk("cont_overlap", 64'(ov), 64'd0);
    chk("cont_steps", 64'(n), 64'd6);
    chk("cont_edits", 64'(ne), 64'd6);
    do_reset();
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    cyc();
    cyc();
    edit_valid = 1'b1; edit_set = 1'b1; edit_row = 3'd1; edit_col = 3'd1;
    cyc();
    edit_valid = 1'b0;
    chk("mid_gen_before", 64'(generation), 64'd1);
    chk("mid_set_before", set_cells, bitm(9));
    reset = 1'b1;
    cyc();
    chk("mid_set", set_cells, 64'd0);
    chk("mid_clear", clear_cells, 64'd0);
    chk("mid_gen", 64'(generation), 64'd0);
    chk("mid_ready", 64'(edit_ready), 64'd1);
    chk("mid_step_en", 64'(step_en), 64'd0);
    reset = 1'b0;
    cyc();
    chk("post_set", set_cells, 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
`ifdef SILIFE_STEPPER_MAX_GEN_EN
    do_reset();
    max_gen = 32'd5; run = 1'b1; period = 24'd2; n = 0;
    for (int c = 0; c < 40; c++) begin
      if (step_en) n++;
      cyc();
    end
    chk("max_pulses", 64'(n), 64'd5);
    chk("max_halted", 64'(halted), 64'd1);
    chk("max_gen", 64'(generation), 64'd5);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/silife_stepper.md
Name: silife_stepper

Overview:
- Generation scheduler for the silife cell matrix; sits between the Wishbone register block and silife_matrix.
- Generates the matrix step-enable pulse from a programmable period timer, with run, pause and single-step control.
- Arbitrates host cell edits (set/clear of one cell) against generation steps, so an edit and a step never land in the same clock.
- Counts completed generations.

Parameters:
- WIDTH, 8, matrix columns.
- HEIGHT, 8, matrix rows.
- PERIOD_BITS, 24, width of the step period register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-running generations.
- step_req  in  1  one-cycle pulse; request a single generation.
- period  in  PERIOD_BITS  clocks between timed steps; 0 is treated as 1.
- edit_valid  in  1  cell edit request.
- edit_ready  out  1  edit accepted when edit_valid && edit_ready.
- edit_set  in  1  1 = set cell, 0 = clear cell.
- edit_row  in  $clog2(HEIGHT)  target row.
- edit_col  in  $clog2(WIDTH)  target column.
- step_en  out  1  one-cycle generation pulse to the matrix enable.
- set_cells  out  HEIGHT*WIDTH  one-hot set mask.
- clear_cells  out  HEIGHT*WIDTH  one-hot clear mask.
- generation  out  32  completed generation count.
- busy  out  1  high when state != S_IDLE or a step is pending.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state S_IDLE; step_en, set_cells, clear_cells, generation, busy, timer and step_pending all 0; edit_ready 1 after the reset cycle.
- Timer:
  - While run=1, counts 0..max(period,1)-1.
  - At terminal count it sets step_pending and wraps to 0.
  - While run=0 it is held at 0.
  - An accepted step_req sets step_pending and restarts the timer at 0.
- step_pending is a single flag. Further requests while it is pending merge, so at most one step is queued.
- FSM states: S_IDLE, S_EDIT, S_STEP.
  - S_IDLE: if edit_valid, go to S_EDIT and latch edit_set/row/col. Otherwise, if step_pending, go to S_STEP.
  - S_EDIT: for one cycle, drive the one-hot mask bit at index row*WIDTH+col on set_cells (edit_set=1) or clear_cells (edit_set=0); the other mask stays 0. Next state is S_STEP if step_pending, else S_IDLE.
  - S_STEP: for one cycle, step_en=1, step_pending cleared, generation incremented (wraps 2^32-1 -> 0). Next state is S_IDLE.
- edit_ready = (state==S_IDLE). It is also high in S_EDIT when no step is pending, which allows back-to-back edits. Fairness: a pending step always follows the current edit, so continuous edits cannot starve steps.
- Latency:
  - Edit handshake at cycle N -> mask asserted exactly at cycle N+1.
  - Step request at cycle N with no edit in flight -> step_en at cycle N+2 (flag set at N+1, S_STEP at N+2).
- Out-of-range row/col (non-power-of-two dimensions): the edit is accepted, both masks stay 0, and the FSM flow is unchanged.
- Simultaneous events:
  - Edit and step_pending together in S_IDLE: the edit goes first.
  - Timer expiry and step_req in the same cycle: one step.
- Changing period mid-count: takes effect at the next comparison. If the timer is already >= the new period-1, it expires on the next cycle.
- Reset mid-operation: any in-flight edit or step is dropped; no mask or step_en pulse appears after reset.

Optional Feature:
- Macro: SILIFE_STEPPER_MAX_GEN_EN.
- When defined, the block adds:
  - input max_gen[31:0];
  - output halted. halted goes to 1 the cycle after generation becomes equal to a nonzero max_gen. While halted, timer expiries and step_req are ignored; edits still work. halted clears on reset, or when run goes 0->1 while generation != max_gen.
- When not defined: no ports added, and generations are unbounded.

Decomposition:
- Package silife_pkg holds:
  - typedef enum stepper_state_t {S_IDLE, S_EDIT, S_STEP};
  - localparam GEN_BITS=32;
  - a function cell_index(row,col,WIDTH).
- One natural sub-module: silife_step_timer, containing the period counter and the expiry pulse.

Test Plan:
- Reset then run=1, period=4 -> step_en pulses every 4 clocks; generation=3 after the 3rd pulse.
- run=0, single step_req -> exactly one step_en two cycles later; generation increments by 1; no further pulses.
- Edit handshake set row=2 col=5 -> set_cells has only bit 21 high for one cycle, clear_cells=0; then clear of the same cell -> clear_cells bit 21.
- Edit edit_valid held high continuously with run=1, period=1 -> edits and step_en alternate; step_en never coincides with a nonzero mask.
- Reset asserted while in S_EDIT -> masks 0 on the following cycle, generation=0, edit_ready=1.
- With SILIFE_STEPPER_MAX_GEN_EN and max_gen=5, run=1, period=2 -> exactly 5 step_en pulses, then halted=1 and no further steps.
